// File: rtl/demux_1x2_2nbit_reg.sv
// Registered 1-to-2 word demultiplexer. One input stream is steered to one of
// two single-entry output buffers, by s or round-robin when alt=1. Each
// channel drains through its own valid/ready handshake and counts deliveries.
module demux_1x2_2nbit_reg #(
   parameter int N  = 3,
   parameter int CW = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              s,
   input  logic              alt,
   input  logic              in_valid,
   input  logic [2**N-1:0]   in_data,
   output logic              in_ready,
   output logic              out0_valid,
   output logic [2**N-1:0]   out0_data,
   input  logic              out0_ready,
   output logic              out1_valid,
   output logic [2**N-1:0]   out1_data,
   input  logic              out1_ready,
   output logic [CW-1:0]     cnt0,
   output logic [CW-1:0]     cnt1
);

   localparam int W = 2**N;

   logic       rr_ptr;
   logic       tgt;
   logic [1:0] slot_free;
   logic       accept;
   logic       load0;
   logic       load1;
   logic       dlv0;
   logic       dlv1;

   // A buffer that is being drained this cycle counts as free, so a channel
   // whose consumer holds ready=1 sustains one word per cycle.
   assign tgt          = alt ? rr_ptr : s;
   assign slot_free[0] = ~out0_valid | out0_ready;
   assign slot_free[1] = ~out1_valid | out1_ready;
   assign in_ready     = en & (tgt ? slot_free[1] : slot_free[0]);
   assign accept       = in_valid & in_ready;
   assign load0        = accept & ~tgt;
   assign load1        = accept & tgt;
   assign dlv0         = out0_valid & out0_ready;
   assign dlv1         = out1_valid & out1_ready;

   // Channel 0 buffer: reload wins over drain; data is held when not loading.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out0_valid <= 1'b0;
         out0_data  <= '0;
      end else if (load0) begin
         out0_valid <= 1'b1;
         out0_data  <= in_data;
      end else if (dlv0) begin
         out0_valid <= 1'b0;
      end
   end

   // Channel 1 buffer: same behaviour as channel 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out1_valid <= 1'b0;
         out1_data  <= '0;
      end else if (load1) begin
         out1_valid <= 1'b1;
         out1_data  <= in_data;
      end else if (dlv1) begin
         out1_valid <= 1'b0;
      end
   end

   // Delivery counters, wrapping naturally at 2**CW.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (dlv0) cnt0 <= cnt0 + CW'(1);
         if (dlv1) cnt1 <= cnt1 + CW'(1);
      end
   end

   // Round-robin pointer advances only on words accepted in round-robin mode,
   // so it stays frozen while alt=0 or while input is blocked.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= 1'b0;
      end else if (accept & alt) begin
         rr_ptr <= ~rr_ptr;
      end
   end

   logic unused_w;
   assign unused_w = (W == 0);

endmodule
